// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_pkg
// Purpose : Shared types and default constants for the SPI slave interface.
//           spi_state_t - FSM state encoding (IDLE / ACTIVE)
//           SPI_DATA_W_DEF - default word width in bits
//           SPI_SYNC_DEF   - default synchronizer depth
// Rev     : 1.0 - initial release
// ============================================================================
package spi_pkg;

  localparam int SPI_DATA_W_DEF = 8;
  localparam int SPI_SYNC_DEF   = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module  : sync_edge_det
// Purpose : Multi-flop synchronizer for one asynchronous input followed by a
//           one-flop edge detector.
// Ports   : clk, rst - clock, synchronous active-high reset
//           din      - asynchronous input
//           level    - synchronized level (STAGES clk after din)
//           rise     - one-clk pulse on a 0->1 transition of level
//           fall     - one-clk pulse on a 1->0 transition of level
// Params  : STAGES  - synchronizer flop count (>= 2)
//           RST_VAL - value every flop takes in reset
// Rev     : 1.0 - initial release
// ============================================================================
module sync_edge_det #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], din};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign level = r_sync[STAGES-1];
  assign rise  = r_sync[STAGES-1] & ~r_prev;
  assign fall  = ~r_sync[STAGES-1] & r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
// Module  : spi_slave_if
// Purpose : Byte-oriented SPI mode-0 slave. SCK/CS_n/MOSI are oversampled in
//           the clk domain; nothing is clocked by SCK.
// Ports   : clk, rst          - system clock, synchronous active-high reset
//           sck_i, cs_n_i,    - asynchronous SPI pins from the master
//           mosi_i
//           miso_o, miso_oe_o - slave data out and its pad output enable
//           rx_data_o         - last completed received word
//           rx_valid_o        - one-clk pulse when rx_data_o updates
//           tx_data_i,        - response word and its write strobe
//           tx_load_i
//           tx_ready_o        - tx buffer empty
//           frame_err_o       - one-clk pulse on CS_n deassert mid-word
//           busy_o            - frame in progress
// Rev     : 1.0 - initial release
// ============================================================================
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W_DEF,
  parameter int SYNC_STAGES = SPI_SYNC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck_i,
  input  logic              cs_n_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_load_i,
  output logic              tx_ready_o,
  output logic              frame_err_o,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(DATA_W - 1);

  // After reset the synchronizers hold their reset value for a few clk before
  // the real pin level arrives; cs_fall is not trusted until then.
  localparam int SETTLE   = SYNC_STAGES + 1;
  localparam int SETTLE_W = $clog2(SETTLE + 1);
  localparam logic [SETTLE_W-1:0] c_SETTLE_CNT = SETTLE_W'(SETTLE);

  // --------------------------------------------------------------------------
  // Input synchronizers
  // --------------------------------------------------------------------------
  logic w_sck_level, w_sck_rise, w_sck_fall;
  logic w_cs_level,  w_cs_rise,  w_cs_fall;
  logic w_mosi,      w_mosi_rise, w_mosi_fall;

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk   (clk),
    .rst   (rst),
    .din   (sck_i),
    .level (w_sck_level),
    .rise  (w_sck_rise),
    .fall  (w_sck_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk   (clk),
    .rst   (rst),
    .din   (cs_n_i),
    .level (w_cs_level),
    .rise  (w_cs_rise),
    .fall  (w_cs_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk   (clk),
    .rst   (rst),
    .din   (mosi_i),
    .level (w_mosi),
    .rise  (w_mosi_rise),
    .fall  (w_mosi_fall)
  );

  logic w_unused;
  assign w_unused = ^{w_sck_level, w_mosi_rise, w_mosi_fall};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  spi_state_t          r_state;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [DATA_W-2:0]   r_rx_shift;   // MSB-side bits of the word in flight
  logic [DATA_W-1:0]   r_tx_shift;
  logic [DATA_W-1:0]   r_tx_buf;
  logic                r_tx_ready;
  logic [DATA_W-1:0]   r_rx_data;
  logic                r_rx_valid;
  logic                r_frame_err;
  logic                r_miso_oe;
  logic                r_armed;
  logic [SETTLE_W-1:0] r_settle;

  logic                w_start;
  logic                w_word_done;
  logic                w_consume;
  logic                w_load;
  logic [DATA_W-1:0]   w_tx_next;

  assign w_start     = (r_state == IDLE) && w_cs_fall && r_armed;
  // cs_rise has priority: a rising SCK in the same clk is dropped.
  assign w_word_done = (r_state == ACTIVE) && !w_cs_rise && w_sck_rise &&
                       (r_bit_cnt == c_LAST_BIT);
  assign w_consume   = w_start || w_word_done;
  // A consume reads the buffer as it was before any same-clk load.
  assign w_tx_next   = r_tx_ready ? '0 : r_tx_buf;
  assign w_load      = tx_load_i && r_tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_rx_shift  <= '0;
      r_tx_shift  <= '0;
      r_tx_buf    <= '0;
      r_tx_ready  <= 1'b1;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_miso_oe   <= 1'b0;
      r_armed     <= 1'b0;
      r_settle    <= '0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;

      // Arm only once CS_n is genuinely seen high after reset, so a frame
      // already in progress at reset release is ignored to its end.
      if (r_settle != c_SETTLE_CNT) begin
        r_settle <= r_settle + SETTLE_W'(1);
      end else if (w_cs_level) begin
        r_armed <= 1'b1;
      end

      if (w_load) begin
        r_tx_buf   <= tx_data_i;
        r_tx_ready <= 1'b0;
      end else if (w_consume) begin
        r_tx_ready <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state    <= ACTIVE;
            r_bit_cnt  <= '0;
            r_tx_shift <= w_tx_next;
            r_miso_oe  <= 1'b1;
          end
        end
        ACTIVE: begin
          if (w_cs_rise) begin
            if (r_bit_cnt != '0) begin
              r_frame_err <= 1'b1;
            end
            r_bit_cnt <= '0;
            r_miso_oe <= 1'b0;
            r_state   <= IDLE;
          end else if (w_sck_rise) begin
            if (w_word_done) begin
              r_rx_data  <= {r_rx_shift, w_mosi};
              r_rx_valid <= 1'b1;
              r_bit_cnt  <= '0;
              r_tx_shift <= w_tx_next;
            end else begin
              r_rx_shift <= {r_rx_shift[DATA_W-3:0], w_mosi};
              r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
            end
          end else if (w_sck_fall && (r_bit_cnt != '0)) begin
            // At bit_cnt==0 the freshly loaded MSB must stay on the line
            // for the first rising edge of the word.
            r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign miso_o      = r_tx_shift[DATA_W-1];
  assign miso_oe_o   = r_miso_oe;
  assign rx_data_o   = r_rx_data;
  assign rx_valid_o  = r_rx_valid;
  assign tx_ready_o  = r_tx_ready;
  assign frame_err_o = r_frame_err;
  assign busy_o      = (r_state == ACTIVE);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_if.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_slave_if
// Purpose : Directed self-checking bench for spi_slave_if, driving SCK at
//           clk/8 from a behavioural SPI master.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_spi_slave_if;

  logic       clk = 1'b0;
  logic       rst;
  logic       sck_i, cs_n_i, mosi_i;
  logic       miso_o, miso_oe_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic [7:0] tx_data_i;
  logic       tx_load_i;
  logic       tx_ready_o;
  logic       frame_err_o;
  logic       busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor state, written only by the monitor process.
  logic [7:0] rx_log [256];
  int         rx_cnt  = 0;
  int         ferr_cnt = 0;

  always #5 clk = ~clk;

  spi_slave_if #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .sck_i       (sck_i),
    .cs_n_i      (cs_n_i),
    .mosi_i      (mosi_i),
    .miso_o      (miso_o),
    .miso_oe_o   (miso_oe_o),
    .rx_data_o   (rx_data_o),
    .rx_valid_o  (rx_valid_o),
    .tx_data_i   (tx_data_i),
    .tx_load_i   (tx_load_i),
    .tx_ready_o  (tx_ready_o),
    .frame_err_o (frame_err_o),
    .busy_o      (busy_o)
  );

  always @(negedge clk) begin
    if (rx_valid_o) begin
      rx_log[rx_cnt[7:0]] <= rx_data_o;
      rx_cnt <= rx_cnt + 1;
    end
    if (frame_err_o) ferr_cnt <= ferr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    cs_n_i = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_high();
    wait_clk(4);
    cs_n_i = 1'b1;
    wait_clk(8);
  endtask

  // Shift nb bits of m (MSB first); s collects MISO sampled at each SCK rise.
  task automatic spi_bits(input logic [7:0] m, input int nb,
                          output logic [7:0] s);
    s = '0;
    for (int i = 0; i < nb; i++) begin
      mosi_i = m[7-i];
      wait_clk(4);
      sck_i = 1'b1;
      s = {s[6:0], miso_o};
      wait_clk(4);
      sck_i = 1'b0;
    end
  endtask

  task automatic tx_load(input logic [7:0] d);
    tx_data_i = d;
    tx_load_i = 1'b1;
    wait_clk(1);
    tx_load_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " miso"},      32'(miso_o),      32'h0);
    check({tag, " miso_oe"},   32'(miso_oe_o),   32'h0);
    check({tag, " rx_data"},   32'(rx_data_o),   32'h0);
    check({tag, " rx_valid"},  32'(rx_valid_o),  32'h0);
    check({tag, " tx_ready"},  32'(tx_ready_o),  32'h1);
    check({tag, " frame_err"}, 32'(frame_err_o), 32'h0);
    check({tag, " busy"},      32'(busy_o),      32'h0);
  endtask

  logic [7:0] s0, s1;
  logic [7:0] exp_rand [64];
  logic [7:0] miso_or;
  int         base, fbase;

  initial begin
    rst = 1'b1; sck_i = 1'b0; cs_n_i = 1'b1; mosi_i = 1'b0;
    tx_data_i = '0; tx_load_i = 1'b0;
    wait_clk(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_clk(8);

    // Single word, empty tx buffer
    base = rx_cnt; fbase = ferr_cnt;
    cs_low();
    check("a5 busy", 32'(busy_o), 32'h1);
    check("a5 miso_oe", 32'(miso_oe_o), 32'h1);
    spi_bits(8'hA5, 8, s0);
    cs_high();
    check("a5 rx count", 32'(rx_cnt - base), 32'd1);
    check("a5 rx data", 32'(rx_log[base[7:0]]), 32'hA5);
    check("a5 rx_data_o", 32'(rx_data_o), 32'hA5);
    check("a5 miso", 32'(s0), 32'h00);
    check("a5 frame_err", 32'(ferr_cnt - fbase), 32'd0);
    check("a5 miso_oe off", 32'(miso_oe_o), 32'h0);
    check("a5 busy off", 32'(busy_o), 32'h0);

    // Preloaded response, 2-byte frame
    tx_load(8'h3C);
    check("3c tx_ready low", 32'(tx_ready_o), 32'h0);
    base = rx_cnt;
    cs_low();
    check("3c tx_ready at cs", 32'(tx_ready_o), 32'h1);
    spi_bits(8'h12, 8, s0);
    spi_bits(8'h34, 8, s1);
    cs_high();
    check("3c rx count", 32'(rx_cnt - base), 32'd2);
    check("3c rx0", 32'(rx_log[base[7:0]]), 32'h12);
    check("3c rx1", 32'(rx_log[8'(base + 1)]), 32'h34);
    check("3c miso0", 32'(s0), 32'h3C);
    check("3c miso1", 32'(s1), 32'h00);

    // Second load while full is ignored
    tx_load(8'h11);
    tx_load(8'h22);
    check("full tx_ready", 32'(tx_ready_o), 32'h0);
    base = rx_cnt;
    cs_low();
    spi_bits(8'h5A, 8, s0);
    cs_high();
    cs_low();
    spi_bits(8'h69, 8, s1);
    cs_high();
    check("full miso first", 32'(s0), 32'h11);
    check("full miso second", 32'(s1), 32'h00);
    check("full rx count", 32'(rx_cnt - base), 32'd2);
    check("full rx1", 32'(rx_log[8'(base + 1)]), 32'h69);

    // Aborted word after 5 bits
    base = rx_cnt; fbase = ferr_cnt;
    cs_low();
    spi_bits(8'hFF, 5, s0);
    cs_high();
    check("abort frame_err", 32'(ferr_cnt - fbase), 32'd1);
    check("abort rx count", 32'(rx_cnt - base), 32'd0);
    check("abort rx_data kept", 32'(rx_data_o), 32'h69);
    cs_low();
    spi_bits(8'h7E, 8, s0);
    cs_high();
    check("7e rx count", 32'(rx_cnt - base), 32'd1);
    check("7e rx data", 32'(rx_log[base[7:0]]), 32'h7E);
    check("7e frame_err", 32'(ferr_cnt - fbase), 32'd1);

    // Reset in the middle of a frame
    tx_load(8'h99);
    base = rx_cnt; fbase = ferr_cnt;
    cs_low();
    spi_bits(8'hF0, 3, s0);
    rst = 1'b1;
    wait_clk(2);
    check_reset_outputs("midrst");
    rst = 1'b0;
    spi_bits(8'h80, 5, s0);
    cs_high();
    check("midrst rx count", 32'(rx_cnt - base), 32'd0);
    check("midrst frame_err", 32'(ferr_cnt - fbase), 32'd0);
    check("midrst busy", 32'(busy_o), 32'h0);
    cs_low();
    spi_bits(8'hC3, 8, s0);
    cs_high();
    check("c3 rx count", 32'(rx_cnt - base), 32'd1);
    check("c3 rx data", 32'(rx_log[base[7:0]]), 32'hC3);
    check("c3 miso", 32'(s0), 32'h00);

    // 64 random words back to back at SCK = clk/8
    base = rx_cnt; fbase = ferr_cnt;
    miso_or = '0;
    cs_low();
    for (int w = 0; w < 64; w++) begin
      exp_rand[w] = 8'($urandom_range(0, 255));
      spi_bits(exp_rand[w], 8, s0);
      miso_or = miso_or | s0;
    end
    cs_high();
    check("rand rx count", 32'(rx_cnt - base), 32'd64);
    for (int w = 0; w < 64; w++) begin
      check($sformatf("rand word %0d", w), 32'(rx_log[8'(base + w)]),
            32'(exp_rand[w]));
    end
    check("rand miso", 32'(miso_or), 32'h0);
    check("rand frame_err", 32'(ferr_cnt - fbase), 32'd0);

    // SCK activity while deselected
    base = rx_cnt;
    spi_bits(8'hAA, 8, s0);
    wait_clk(8);
    check("idle sck rx count", 32'(rx_cnt - base), 32'd0);
    check("idle sck busy", 32'(busy_o), 32'h0);
    check("idle sck miso_oe", 32'(miso_oe_o), 32'h0);
    check("idle sck frame_err", 32'(ferr_cnt - fbase), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
